ids_chebyshev_coeff_sequencer: RTL and testbench

IDS_CHEBYSHEV_COEFF_SEQUENCER -- requirements
Module: ids_chebyshev_coeff_sequencer

---
 rtl/ids_chebyshev_pkg.sv | 15 +
 rtl/ids_chebyshev_coeff_bank.sv | 43 ++++
 rtl/ids_chebyshev_coeff_sequencer.sv | 106 ++++++++++
 tb/tb_ids_chebyshev_coeff_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ids_chebyshev_pkg.sv
// Shared definitions for the Chebyshev evaluation blocks: default widths,
// the supported polynomial order and the sequencer state encoding.
package ids_chebyshev_pkg;

  localparam int WORD_LENGTH_DEF  = 16;
  localparam int COEFF_LENGTH_DEF = 16;
  localparam int MAX_ORDER_DEF    = 8;
  localparam int ADDR_WIDTH_DEF   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ids_chebyshev_coeff_bank.sv
// Coefficient table c_0..c_MAX_ORDER: one synchronous write port, one
// combinational read port, cleared to zero by reset.
module ids_chebyshev_coeff_bank
  import ids_chebyshev_pkg::*;
#(
  parameter int COEFF_LENGTH = COEFF_LENGTH_DEF,
  parameter int MAX_ORDER    = MAX_ORDER_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [COEFF_LENGTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [COEFF_LENGTH-1:0] rdata
);

  localparam int DEPTH = MAX_ORDER + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(MAX_ORDER);

  logic [COEFF_LENGTH-1:0] mem [DEPTH];

  // Table storage: reset clears every entry, otherwise in-range writes land.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr <= MAX_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read; out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    if (raddr <= MAX_IDX) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/ids_chebyshev_coeff_sequencer.sv
// Accepts one sample x, then streams coefficients c_N..c_0 (Clenshaw order)
// alongside x to the computation stage, one beat per out_valid/out_ready
// transfer. Table writes are only honoured while idle.
module ids_chebyshev_coeff_sequencer
  import ids_chebyshev_pkg::*;
#(
  parameter int WORD_LENGTH  = WORD_LENGTH_DEF,
  parameter int COEFF_LENGTH = COEFF_LENGTH_DEF,
  parameter int MAX_ORDER    = MAX_ORDER_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [COEFF_LENGTH-1:0] cfg_data,
  input  logic [ADDR_WIDTH-1:0]   cfg_order,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_LENGTH-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_LENGTH-1:0]  out_data,
  output logic [COEFF_LENGTH-1:0] out_coeff,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(MAX_ORDER);

  // Requested orders above the table size are clamped to the top entry.
  function automatic logic [ADDR_WIDTH-1:0] clamp_order(input logic [ADDR_WIDTH-1:0] ord);
    return (ord > MAX_IDX) ? MAX_IDX : ord;
  endfunction

  seq_state_t              state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   order_r;
  logic [WORD_LENGTH-1:0]  x_r;
  logic                    err_r;
  logic                    bank_we;
  logic [COEFF_LENGTH-1:0] bank_rdata;

  // Writes are accepted only while idle and in range; the bank applies them
  // at the same edge that may accept a sample, so that sample sees the new value.
  assign bank_we = cfg_we && (state == ST_IDLE) && (cfg_addr <= MAX_IDX);

  ids_chebyshev_coeff_bank #(
    .COEFF_LENGTH (COEFF_LENGTH),
    .MAX_ORDER    (MAX_ORDER),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_bank (
    .clock (clock),
    .reset (reset),
    .we    (bank_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx),
    .rdata (bank_rdata)
  );

  // Sequencer FSM: accept in IDLE, walk idx down to zero in ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      order_r <= '0;
      x_r     <= '0;
      err_r   <= 1'b0;
    end else begin
      err_r <= cfg_we && ((state != ST_IDLE) || (cfg_addr > MAX_IDX));
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_r     <= in_data;
            order_r <= clamp_order(cfg_order);
            idx     <= clamp_order(cfg_order);
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (out_ready) begin
            if (idx == '0) begin
              state <= ST_IDLE;
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE) && !reset;
  assign out_valid = (state == ST_ISSUE);
  assign out_first = out_valid && (idx == order_r);
  assign out_last  = out_valid && (idx == '0);
  assign out_data  = x_r;
  assign out_coeff = bank_rdata;
  assign busy      = (state != ST_IDLE);
  assign cfg_err   = err_r;

endmodule

// File: tb/tb_ids_chebyshev_coeff_sequencer.sv
// Bench for the Chebyshev coefficient sequencer: directed samples push their
// expected beats into a queue, a negedge monitor pops on every transfer.
module tb_ids_chebyshev_coeff_sequencer;

  typedef struct {
    logic [15:0] coeff;
    logic [15:0] data;
    logic        first;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [3:0]  cfg_order;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_coeff;
  logic        out_first;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];
  logic [15:0] model_tbl [0:8];

  always #5 clock = ~clock;

  ids_chebyshev_coeff_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_order (cfg_order),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_coeff (out_coeff),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push_seq(input logic [15:0] x, input int ord);
    int eff;
    beat_t b;
    eff = (ord > 8) ? 8 : ord;
    for (int k = eff; k >= 0; k--) begin
      b.coeff = model_tbl[k];
      b.data  = x;
      b.first = (k == eff);
      b.last  = (k == 0);
      exp_q.push_back(b);
    end
  endtask

  // Write one table entry while idle; check the error pulse the next cycle.
  task automatic write(input logic [3:0] addr, input logic [15:0] val, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = val;
    step();
    cfg_we = 1'b0;
    check($sformatf("cfg_err_addr%0d", addr), cfg_err, exp_err);
    if (!exp_err) model_tbl[addr] = val;
  endtask

  task automatic send(input logic [15:0] x, input logic [3:0] ord);
    push_seq(x, ord);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_data = x; cfg_order = ord;
    step();
    in_valid = 1'b0;
    check("first_beat_latency", out_valid, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      step();
      n++;
    end
    check("drain_timeout", n < 60, 1'b1);
  endtask

  // Monitor: compare each transferred beat and watch stability under stall.
  logic        stalled = 1'b0;
  logic [15:0] hold_coeff, hold_data;
  logic        hold_first, hold_last;
  always @(negedge clock) begin
    if (reset) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_coeff_held", out_coeff, hold_coeff);
        check("stall_data_held", out_data, hold_data);
        check("stall_marks_held", {out_first, out_last}, {hold_first, hold_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_coeff, 32'hDEAD);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_coeff", out_coeff, b.coeff);
          check("beat_data", out_data, b.data);
          check("beat_first", out_first, b.first);
          check("beat_last", out_last, b.last);
        end
      end
      stalled    <= out_valid && !out_ready;
      hold_coeff <= out_coeff;
      hold_data  <= out_data;
      hold_first <= out_first;
      hold_last  <= out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i <= 8; i++) model_tbl[i] = 16'h0000;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_order = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_out_coeff", out_coeff, 16'h0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);
    step();

    // Basic order-3 sequence with consecutive beats.
    write(4'd0, 16'h1000, 1'b0);
    write(4'd1, 16'h0800, 1'b0);
    write(4'd2, 16'h0400, 1'b0);
    write(4'd3, 16'h0200, 1'b0);
    send(16'h4000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check("consecutive_beat", out_valid, 1'b1);
      check("busy_in_issue", busy, 1'b1);
      check("in_ready_low_issue", in_ready, 1'b0);
      step();
    end
    check("in_ready_after_last", in_ready, 1'b1);
    check("valid_low_after_last", out_valid, 1'b0);

    // Backpressure on beat 2 for three cycles.
    send(16'h4000, 4'd3);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_coeff", out_coeff, 16'h0400);
      step();
    end
    out_ready = 1'b1;
    drain();

    // cfg write during ISSUE is rejected; old c1 survives.
    send(16'h1234, 4'd3);
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'hABCD;
    step();
    cfg_we = 1'b0;
    check("cfg_err_issue", cfg_err, 1'b1);
    step();
    check("cfg_err_one_cycle", cfg_err, 1'b0);
    drain();
    send(16'h2222, 4'd1);
    drain();
    write(4'd9, 16'h5555, 1'b1);

    // Order 0 with a write to c0 in the same cycle as acceptance.
    model_tbl[0] = 16'h7FFF;
    push_seq(16'h0101, 0);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h7FFF;
    in_valid = 1'b1; in_data = 16'h0101; cfg_order = 4'd0;
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    check("ord0_first", out_first, 1'b1);
    check("ord0_last", out_last, 1'b1);
    check("ord0_coeff", out_coeff, 16'h7FFF);
    drain();

    // Order clamping: 15 -> 8, nine beats.
    write(4'd4, 16'h0100, 1'b0);
    write(4'd5, 16'h0080, 1'b0);
    write(4'd6, 16'h0040, 1'b0);
    write(4'd7, 16'h0020, 1'b0);
    write(4'd8, 16'h0010, 1'b0);
    send(16'h0F0F, 4'd15);
    check("clamp_first_coeff", out_coeff, 16'h0010);
    check("clamp_queue_len", exp_q.size(), 9);
    drain();

    // Reset in the middle of a sequence.
    send(16'h3333, 4'd3);
    step();
    step();
    reset = 1'b1;
    step();
    check("abort_valid", out_valid, 1'b0);
    check("abort_last", out_last, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_coeff", out_coeff, 16'h0);
    check("abort_remaining", exp_q.size(), 2);
    exp_q.delete();
    for (int i = 0; i <= 8; i++) model_tbl[i] = 16'h0000;
    reset = 1'b0;
    #1;
    check("in_ready_post_abort", in_ready, 1'b1);
    step();
    send(16'h4444, 4'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
